// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling, 3-sample majority vote per bit,
// valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned OSR    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned DIV = CLK_HZ / (BAUD * OSR);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DivMax = DW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q;
  logic        rxd_m_q, rxd_s_q, rxd_prev_q;
  logic [DW-1:0] div_q;
  logic [3:0]  phase_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        s7_q, s8_q;

  logic tick, decide, wrap, maj, fall;

  assign tick   = (state_q != StIdle) && (div_q == DivMax);
  // Phase value names the tick that advances it, so "tick 9" is the tick leaving phase 8.
  assign decide = tick && (phase_q == 4'd8);
  assign wrap   = tick && (phase_q == 4'd15);
  assign maj    = (s7_q & s8_q) | (s7_q & rxd_s_q) | (s8_q & rxd_s_q);
  assign fall   = rxd_prev_q & ~rxd_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rxd_m_q      <= 1'b1;
      rxd_s_q      <= 1'b1;
      rxd_prev_q   <= 1'b1;
      div_q        <= '0;
      phase_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      s7_q         <= 1'b0;
      s8_q         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_busy      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rxd_m_q      <= rxd;
      rxd_s_q      <= rxd_m_q;
      rxd_prev_q   <= rxd_s_q;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;

      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (state_q != StIdle) div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        phase_q <= phase_q + 4'd1;
        if (phase_q == 4'd6) s7_q <= rxd_s_q;
        if (phase_q == 4'd7) s8_q <= rxd_s_q;
      end

      case (state_q)
        StIdle: begin
          if (fall) begin
            state_q <= StStart;
            div_q   <= '0;
            phase_q <= '0;
            rx_busy <= 1'b1;
          end
        end
        StStart: begin
          if (decide && maj) begin
            state_q <= StIdle;
            div_q   <= '0;
            phase_q <= '0;
            rx_busy <= 1'b0;
          end else if (wrap) begin
            state_q   <= StData;
            bit_idx_q <= '0;
          end
        end
        StData: begin
          if (decide) shift_q <= {maj, shift_q[7:1]};
          if (wrap) begin
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end
        end
        StStop: begin
          if (decide) begin
            state_q <= StIdle;
            div_q   <= '0;
            phase_q <= '0;
            rx_busy <= 1'b0;
            if (!maj) begin
              rx_frame_err <= 1'b1;
            end else if (!rx_valid || rx_ready) begin
              // A byte consumed this same cycle frees the register for the new one.
              rx_data  <= shift_q;
              rx_valid <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a negedge monitor pops them.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rxd          (rxd),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #10 clk = ~clk;

  typedef enum logic [7:0] {EvByte = 8'd1, EvFerr = 8'd2, EvOvr = 8'd3} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  passed = 0;
  int  t;
  logic seen;
  logic valid_prev = 1'b0;
  logic ready_prev = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h expected none", k, d);
    end else begin
      e = exp_q.pop_front();
      check("event", {8'(k), d}, {8'(e.kind), e.data});
    end
  endtask

  // Monitor: a byte is new when valid is high and the previous one was not still held.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && (!valid_prev || ready_prev)) observe(EvByte, rx_data);
      if (rx_frame_err) observe(EvFerr, 8'h00);
      if (rx_overrun) observe(EvOvr, 8'h00);
    end
    valid_prev = rx_valid;
    ready_prev = rx_ready;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int n, input logic stop);
    rxd = 1'b0;
    cyc(n);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(n);
    end
    rxd = stop;
    cyc(n);
    rxd = 1'b1;
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b0;
    cyc(5);
    check("reset_outputs", {rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun}, 0);
    rst = 1'b0;
    cyc(20);

    // 0x45 with latency measurement from START entry to rx_valid.
    expect_ev(EvByte, 8'h45);
    fork
      send_frame(8'h45, 434, 1'b1);
      begin
        t = 0;
        while (!rx_busy && t < 100) begin @(negedge clk); t++; end
        check("busy_rise", rx_busy, 1);
        t = 0;
        while (!rx_valid && t < 5000) begin @(negedge clk); t++; end
        check_range("valid_latency", t, 4128, 4134);
      end
    join
    cyc(100);
    check("hold_valid", rx_valid, 1);
    check("hold_data", rx_data, 8'h45);
    pulse_ready();
    check("valid_cleared", rx_valid, 0);

    // Short low glitch: false start.
    seen = 1'b0;
    rxd = 1'b0;
    for (int i = 0; i < 100; i++) begin cyc(1); seen |= rx_busy; end
    rxd = 1'b1;
    for (int i = 0; i < 400; i++) begin cyc(1); seen |= rx_busy; end
    check("glitch_busy_seen", seen, 1);
    check("glitch_busy_low", rx_busy, 0);
    check("glitch_no_valid", rx_valid, 0);

    // Back-to-back, consumer stalled: first byte kept, second dropped.
    expect_ev(EvByte, 8'h12);
    expect_ev(EvOvr, 8'h00);
    send_frame(8'h12, 434, 1'b1);
    send_frame(8'h34, 434, 1'b1);
    cyc(50);
    check("overrun_keeps_old", rx_data, 8'h12);
    check("overrun_valid", rx_valid, 1);
    pulse_ready();
    cyc(50);

    // Back-to-back, consumer always ready.
    rx_ready = 1'b1;
    expect_ev(EvByte, 8'h12);
    expect_ev(EvByte, 8'h34);
    send_frame(8'h12, 434, 1'b1);
    send_frame(8'h34, 434, 1'b1);
    cyc(50);
    rx_ready = 1'b0;
    check("b2b_last_data", rx_data, 8'h34);
    check("b2b_valid_low", rx_valid, 0);

    // Framing error, then a good frame left held.
    expect_ev(EvFerr, 8'h00);
    send_frame(8'hA5, 434, 1'b0);
    cyc(100);
    check("ferr_no_valid", rx_valid, 0);
    expect_ev(EvByte, 8'h3C);
    send_frame(8'h3C, 434, 1'b1);
    cyc(50);
    check("after_ferr_data", rx_data, 8'h3C);

    // Reset mid-DATA while 0x3C is still held.
    fork
      send_frame(8'h55, 434, 1'b1);
      begin
        cyc(434 * 4);
        check("busy_before_rst", rx_busy, 1);
        rst = 1'b1;
        #1;
        check("rst_outputs", {rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun}, 0);
      end
    join
    cyc(10);
    rst = 1'b0;
    cyc(50);
    expect_ev(EvByte, 8'hC3);
    send_frame(8'hC3, 434, 1'b1);
    cyc(50);
    check("post_rst_data", rx_data, 8'hC3);
    pulse_ready();

    // +/-3% baud mismatch.
    rx_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      int n;
      n = (r == 0) ? 447 : 421;
      expect_ev(EvByte, 8'h00);
      send_frame(8'h00, n, 1'b1);
      cyc(30);
      expect_ev(EvByte, 8'hFF);
      send_frame(8'hFF, n, 1'b1);
      cyc(30);
      expect_ev(EvByte, 8'h80);
      send_frame(8'h80, n, 1'b1);
      cyc(30);
    end
    rx_ready = 1'b0;

    cyc(200);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
